// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: owner of the MAC schedule. A start request clears the
// accumulator, walks N_TAPS operand addresses, lines the MAC enables up with
// the operand memory read latency and holds done until acknowledged.
//
// Handshakes: i_start is a request level sampled only in IDLE (no queuing);
// o_done is a level held high until i_ack is sampled in DONE, after which the
// block returns to IDLE for at least one cycle. i_abort beats i_ack.
module mac_seq_ctrl #(
  parameter int N_TAPS = 8,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_rst_mac,
  output logic              o_addr_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_mac_en,
  output logic              o_last,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal compare value; the counter never has to wrap within a job.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TAPS - 1);

  state_t state;
  state_t state_next;

  logic abort_take;

  // Next values of the registered outputs.
  logic              busy_n;
  logic              rst_mac_n;
  logic              addr_vld_n;
  logic [ADDR_W-1:0] addr_n;
  logic              addr_last_n;
  logic              done_n;

  // Registered outputs (before latency alignment).
  logic              busy_q;
  logic              rst_mac_q;
  logic              addr_vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_last_q;
  logic              done_q;

  // Latency-aligned enable and last marker.
  logic mac_en_w;
  logic last_w;

  // Abort only acts outside IDLE.
  assign abort_take = (state != S_IDLE) && i_abort;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_RUN;
      S_RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_next = (RD_LAT > 0) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: if (last_w) state_next = S_DONE;
      S_DONE:  if (i_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_take) state_next = S_IDLE;
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    busy_n     = (state_next != S_IDLE);
    rst_mac_n  = (state_next == S_CLEAR) || abort_take;
    addr_vld_n = (state_next == S_RUN);
    addr_n     = '0;
    if ((state == S_RUN) && (state_next == S_RUN)) begin
      addr_n = addr_q + ADDR_W'(1);
    end
    addr_last_n = addr_vld_n && (addr_n == LAST_ADDR);
    done_n      = (state_next == S_DONE);
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q      <= 1'b0;
      rst_mac_q   <= 1'b0;
      addr_vld_q  <= 1'b0;
      addr_q      <= '0;
      addr_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q      <= busy_n;
      rst_mac_q   <= rst_mac_n;
      addr_vld_q  <= addr_vld_n;
      addr_q      <= addr_n;
      addr_last_q <= addr_last_n;
      done_q      <= done_n;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_no_lat
      // Memory data is valid in the same cycle as the request.
      assign mac_en_w = addr_vld_q;
      assign last_w   = addr_last_q;
    end else begin : g_lat
      logic [RD_LAT-1:0] vld_sr;
      logic [RD_LAT-1:0] last_sr;

      // Delay line for enable and last; flushed on abort so nothing in
      // flight can reach the accumulator afterwards.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          vld_sr  <= '0;
          last_sr <= '0;
        end else if (abort_take) begin
          vld_sr  <= '0;
          last_sr <= '0;
        end else begin
          vld_sr[0]  <= addr_vld_q;
          last_sr[0] <= addr_last_q;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
          end
        end
      end

      assign mac_en_w = vld_sr[RD_LAT-1];
      assign last_w   = last_sr[RD_LAT-1];
    end
  endgenerate

  assign o_busy     = busy_q;
  assign o_rst_mac  = rst_mac_q;
  assign o_addr_vld = addr_vld_q;
  assign o_addr     = addr_q;
  assign o_mac_en   = mac_en_w;
  assign o_last     = last_w;
  assign o_done     = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: several parameterisations share one stimulus
// stream; a job-timeline model predicts every output each cycle.
module tb_mac_seq_ctrl;

  localparam int NI = 6;
  localparam int N_A  [NI] = '{8, 8, 8, 8, 1, 1};
  localparam int AW_A [NI] = '{3, 3, 3, 3, 1, 1};
  localparam int L_A  [NI] = '{1, 0, 4, 2, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ack = 1'b0;

  logic       busy_a    [NI];
  logic       rst_mac_a [NI];
  logic       addr_vld_a[NI];
  logic [2:0] addr_a    [NI];
  logic       mac_en_a  [NI];
  logic       last_a    [NI];
  logic       done_a    [NI];

  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model state: whether a job is active, and which cycle of it we are in
  // (cycle 1 is the clear cycle); pulse marks the clear after an abort.
  bit m_job  [NI];
  int m_p    [NI];
  bit m_pulse[NI];

  int beats[NI];
  int lasts[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int AW = AW_A[g];
    logic [AW-1:0] addr_w;
    mac_seq_ctrl #(.N_TAPS(N_A[g]), .ADDR_W(AW), .RD_LAT(L_A[g])) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_ack(ack), .o_busy(busy_a[g]), .o_rst_mac(rst_mac_a[g]),
      .o_addr_vld(addr_vld_a[g]), .o_addr(addr_w), .o_mac_en(mac_en_a[g]),
      .o_last(last_a[g]), .o_done(done_a[g])
    );
    assign addr_a[g] = 3'(addr_w);
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Job-timeline model.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_job[k] = 1'b0; m_p[k] = 0; m_pulse[k] = 1'b0;
      end else if (m_job[k]) begin
        if (abort) begin
          m_job[k] = 1'b0; m_pulse[k] = 1'b1;
        end else if (m_p[k] >= N_A[k] + 2 + L_A[k] && ack) begin
          m_job[k] = 1'b0; m_pulse[k] = 1'b0;
        end else begin
          m_p[k] = m_p[k] + 1; m_pulse[k] = 1'b0;
        end
      end else begin
        m_pulse[k] = 1'b0;
        if (start) begin
          m_job[k] = 1'b1; m_p[k] = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus beat bookkeeping.
  always @(negedge clk) begin : cmp
    int n, l, p;
    bit j, vld;
    if (cmp_en) begin
      for (int k = 0; k < NI; k++) begin
        n = N_A[k]; l = L_A[k]; p = m_p[k]; j = m_job[k];
        vld = j && p >= 2 && p <= n + 1;
        chk("busy", k, busy_a[k], j);
        chk("rst_mac", k, rst_mac_a[k], (j && p == 1) || (!j && m_pulse[k]));
        chk("addr_vld", k, addr_vld_a[k], vld);
        chk("addr", k, addr_a[k], vld ? p - 2 : 0);
        chk("mac_en", k, mac_en_a[k], j && p >= 2 + l && p <= n + 1 + l);
        chk("last", k, last_a[k], j && p == n + 1 + l);
        chk("done", k, done_a[k], j && p >= n + 2 + l);
        if (mac_en_a[k]) beats[k]++;
        if (last_a[k]) lasts[k]++;
      end
    end
  end

  // Full job with ack in cycle 14; checks beat and last totals per instance.
  task automatic run_job(input string nm);
    int b0[NI];
    int l0[NI];
    tick(); start = 1'b1;
    for (int k = 0; k < NI; k++) begin b0[k] = beats[k]; l0[k] = lasts[k]; end
    for (int c = 1; c <= 15; c++) begin
      tick(); start = 1'b0; ack = (c == 14);
    end
    for (int k = 0; k < NI; k++) begin
      chk({nm, "_beats"}, k, beats[k] - b0[k], N_A[k]);
      chk({nm, "_lasts"}, k, lasts[k] - l0[k], 1);
      chk({nm, "_idle"}, k, busy_a[k], 0);
    end
  endtask

  initial begin : drive
    int b0[NI];
    // Reset
    tick(); cmp_en = 1'b1;
    tick();
    chk("reset_busy", 0, busy_a[0], 0);
    chk("reset_addr", 0, addr_a[0], 0);
    chk("reset_mac_en", 2, mac_en_a[2], 0);
    tick(); rst_n = 1'b1;
    tick(); tick();

    // Nominal job, stray starts in RUN (5) and DONE (12), ack at 14
    tick(); start = 1'b1;
    for (int k = 0; k < NI; k++) b0[k] = beats[k];
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = (c == 5 || c == 12);
      ack = (c == 14);
      case (c)
        1:  begin chk("nom_rst_c1", 0, rst_mac_a[0], 1); chk("nom_busy_c1", 0, busy_a[0], 1); end
        2:  begin chk("nom_addr_c2", 0, addr_a[0], 0); chk("nom_en_c2", 0, mac_en_a[0], 0);
                  chk("n1_last_c2", 5, last_a[5], 1); end
        3:  begin chk("nom_en_c3", 0, mac_en_a[0], 1); chk("n1_last_c3", 4, last_a[4], 1);
                  chk("n1_done_c3", 5, done_a[5], 1); end
        6:  begin chk("nom_rst_c6", 0, rst_mac_a[0], 0); chk("nom_addr_c6", 0, addr_a[0], 4); end
        9:  begin chk("nom_addr_c9", 0, addr_a[0], 7); chk("lat0_last_c9", 1, last_a[1], 1); end
        10: begin chk("nom_last_c10", 0, last_a[0], 1); chk("nom_vld_c10", 0, addr_vld_a[0], 0);
                  chk("lat0_done_c10", 1, done_a[1], 1); end
        11: chk("nom_done_c11", 0, done_a[0], 1);
        13: begin chk("lat4_last_c13", 2, last_a[2], 1); chk("nom_rst_c13", 0, rst_mac_a[0], 0); end
        14: chk("lat4_done_c14", 2, done_a[2], 1);
        15: begin chk("nom_busy_c15", 0, busy_a[0], 0); chk("nom_done_c15", 0, done_a[0], 0); end
        default: ;
      endcase
    end
    for (int k = 0; k < NI; k++) chk("nom_beats", k, beats[k] - b0[k], N_A[k]);

    // Start held high through ack: relaunch two cycles after ack
    tick(); start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      tick();
      start = (c < 16);
      ack = (c == 14 || c == 29);
      case (c)
        15: begin chk("hold_busy_c15", 0, busy_a[0], 0); chk("hold_rst_c15", 0, rst_mac_a[0], 0); end
        16: begin chk("hold_rst_c16", 0, rst_mac_a[0], 1);
                  for (int k = 0; k < NI; k++) b0[k] = beats[k]; end
        17: chk("hold_addr_c17", 0, addr_vld_a[0], 1);
        30: begin chk("hold_busy_c30", 0, busy_a[0], 0); chk("hold_beats", 0, beats[0] - b0[0], 8); end
        default: ;
      endcase
    end

    // Abort (with ack) at cycle 5: inst3 is at address 3
    tick(); start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 5);
      ack = (c == 5);
      case (c)
        5: chk("abort_addr_c5", 3, addr_a[3], 3);
        6: begin
          chk("abort_rst_c6", 3, rst_mac_a[3], 1); chk("abort_busy_c6", 3, busy_a[3], 0);
          chk("abort_done_rst_c6", 4, rst_mac_a[4], 1); chk("abort_done_c6", 4, done_a[4], 0);
          for (int k = 0; k < NI; k++) b0[k] = beats[k];
        end
        20: for (int k = 0; k < NI; k++) chk("abort_no_beats", k, beats[k] - b0[k], 0);
        default: ;
      endcase
    end
    run_job("after_abort");

    // Asynchronous reset in the middle of DRAIN
    tick(); start = 1'b1;
    for (int c = 1; c <= 10; c++) begin tick(); start = 1'b0; end
    chk("drain_en_c10", 3, mac_en_a[3], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 3, busy_a[3], 0);
    chk("arst_en", 3, mac_en_a[3], 0);
    chk("arst_en", 2, mac_en_a[2], 0);
    chk("arst_last", 2, last_a[2], 0);
    tick(); tick(); rst_n = 1'b1;
    for (int k = 0; k < NI; k++) b0[k] = beats[k];
    repeat (12) tick();
    for (int k = 0; k < NI; k++) chk("arst_no_beats", k, beats[k] - b0[k], 0);
    run_job("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
